// File: rtl/fifo_rd_streamer_if.sv
// fifo_rd_streamer_if: upstream FIFO read port and downstream valid/ready stream of fifo_rd_streamer
//   en_i, fifo_empty_i, fifo_rdata_i, fifo_rd_en_o : upstream synchronous FIFO side
//   m_valid_o, m_ready_i, m_data_o, m_last_o       : downstream packet stream side
//   beat_cnt_o                                     : transfers since reset, modulo 2^16
interface fifo_rd_streamer_if #(
  parameter int WIDTH = 8
);
  logic             en_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_rdata_i;
  logic             fifo_rd_en_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;
  logic [15:0]      beat_cnt_o;
  modport slave (
    input  en_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, beat_cnt_o
  );
  modport master (
    output en_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o, beat_cnt_o
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: reads an upstream synchronous FIFO into a 3-entry buffer and streams it out as PKT_LEN-beat packets
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : fifo_rd_streamer_if.slave (FIFO read port, output stream, beat counter)
module fifo_rd_streamer #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  fifo_rd_streamer_if.slave bus
);
  logic [WIDTH-1:0] buf_q [3];
  logic [1:0]       rptr_q, rptr_d, wptr_q, wptr_d, cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [15:0]      beats_q;
  logic             infl_q, rd_en, xfer, last;
  // Reserve a slot for the word already in flight so the buffer can never overflow;
  // the ready input is deliberately left out to keep it off the read-request path.
  assign rd_en = rst_i && bus.en_i && !bus.fifo_empty_i && ({1'b0, cnt_q} + {2'b0, infl_q} < 3'd3);
  assign xfer  = bus.m_valid_o && bus.m_ready_i;
  assign last  = idx_q == 8'(PKT_LEN - 1);
  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = cnt_q != 2'd0;
  assign bus.m_data_o     = buf_q[rptr_q];
  assign bus.m_last_o     = bus.m_valid_o && last;
  assign bus.beat_cnt_o   = beats_q;
  always_comb begin
    wptr_d = infl_q ? (wptr_q == 2'd2 ? 2'd0 : wptr_q + 2'd1) : wptr_q;
    rptr_d = xfer ? (rptr_q == 2'd2 ? 2'd0 : rptr_q + 2'd1) : rptr_q;
    cnt_d  = cnt_q + {1'b0, infl_q} - {1'b0, xfer};
    idx_d  = xfer ? (last ? 8'd0 : idx_q + 8'd1) : idx_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q   <= '{default: '0};
      rptr_q  <= 2'd0;
      wptr_q  <= 2'd0;
      cnt_q   <= 2'd0;
      idx_q   <= 8'd0;
      beats_q <= 16'd0;
      infl_q  <= 1'b0;
    end else begin
      // FIFO data becomes valid the cycle after the request, hence capture on inflight
      if (infl_q) buf_q[wptr_q] <= bus.fifo_rdata_i;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      beats_q <= beats_q + 16'(xfer);
      infl_q  <= rd_en;
    end
  end
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: self-checking bench for fifo_rd_streamer against a word-order scoreboard
module tb_fifo_rd_streamer;
  localparam int PKT_LEN = 4;
  localparam int MAXW    = 1 << 17;
  typedef struct {
    int         nwords;
    logic [7:0] base;
    int         exp_reads;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [7:0] words [MAXW];
  int n_push = 0;
  int n_pop = 0;
  int exp_idx = 0;
  int total = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit pv = 1'b0;
  bit pr = 1'b0;
  bit pl = 1'b0;
  logic [7:0] pd = 8'd0;
  vec_t vecs [5];
  fifo_rd_streamer_if #(.WIDTH(8)) bus ();
  fifo_rd_streamer #(.WIDTH(8), .PKT_LEN(PKT_LEN)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );
  always #5 clk_i = ~clk_i;
  // Upstream synchronous FIFO: data appears on the edge that accepts the read
  assign bus.fifo_empty_i = (n_pop == n_push);
  always @(posedge clk_i) begin
    if (bus.fifo_rd_en_o) begin
      bus.fifo_rdata_i <= words[n_pop];
      n_pop <= n_pop + 1;
    end
  end
  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
  endtask
  // Scoreboard: every transfer must carry the next unread FIFO word in order; a reset drops
  // everything already read from the FIFO, so the next expected word is the next unread one.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      exp_idx = n_pop;
      total = 0;
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", int'(bus.m_valid_o), 1);
        check("hold_data", int'(bus.m_data_o), int'(pd));
        check("hold_last", int'(bus.m_last_o), int'(pl));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        check("xfer_pending", int'(exp_idx < n_push), 1);
        check("xfer_data", int'(bus.m_data_o), int'(words[exp_idx % MAXW]));
        check("xfer_last", int'(bus.m_last_o), int'((total % PKT_LEN) == PKT_LEN - 1));
        check("xfer_beats", int'(bus.beat_cnt_o), total % 65536);
        exp_idx++;
        total++;
      end
      pv = bus.m_valid_o;
      pr = bus.m_ready_i;
      pd = bus.m_data_o;
      pl = bus.m_last_o;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [7:0] w);
    words[n_push] = w;
    n_push++;
  endtask
  task automatic drain(input int bound);
    int t = 0;
    while (exp_idx != n_push && t < bound) begin
      step(1);
      t++;
    end
    check("drain", exp_idx, n_push);
    step(2);
  endtask
  task automatic do_reset();
    rst_i = 1'b0;
    step(2);
    rst_i = 1'b1;
    step(1);
  endtask
  initial begin
    int n0, d0, t;
    vecs[0] = '{1, 8'h10, 1, 1'b1, 8'h10};
    vecs[1] = '{2, 8'h20, 2, 1'b1, 8'h20};
    vecs[2] = '{3, 8'h30, 3, 1'b1, 8'h30};
    vecs[3] = '{5, 8'h50, 3, 1'b1, 8'h50};
    vecs[4] = '{0, 8'h00, 0, 1'b0, 8'h00};
    rst_i = 1'b0;
    bus.en_i = 1'b0;
    bus.m_ready_i = 1'b0;
    bus.fifo_rdata_i = 8'h00;
    step(2);
    check("rst_valid", int'(bus.m_valid_o), 0);
    check("rst_last", int'(bus.m_last_o), 0);
    check("rst_beats", int'(bus.beat_cnt_o), 0);
    check("rst_data", int'(bus.m_data_o), 0);
    // Single word: a pending word and en_i high must not read while reset is held
    push(8'hA5);
    bus.en_i = 1'b1;
    bus.m_ready_i = 1'b1;
    step(1);
    check("rst_rd_en", int'(bus.fifo_rd_en_o), 0);
    rst_i = 1'b1;
    #1;
    check("single_rd_en_n", int'(bus.fifo_rd_en_o), 1);
    check("single_valid_n", int'(bus.m_valid_o), 0);
    step(1);
    check("single_rd_en_n1", int'(bus.fifo_rd_en_o), 0);
    check("single_valid_n1", int'(bus.m_valid_o), 0);
    step(1);
    check("single_valid_n2", int'(bus.m_valid_o), 1);
    check("single_data_n2", int'(bus.m_data_o), 'hA5);
    check("single_last_n2", int'(bus.m_last_o), 0);
    step(1);
    check("single_valid_n3", int'(bus.m_valid_o), 0);
    check("single_beats", int'(bus.beat_cnt_o), 1);
    // Streaming from reset: eight back-to-back beats, packet ends on 4 and 8
    do_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    t = 0;
    while (!bus.m_valid_o && t < 20) begin
      step(1);
      t++;
    end
    check("stream_start", int'(bus.m_valid_o), 1);
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", int'(bus.m_valid_o), 1);
      check("stream_data", int'(bus.m_data_o), i + 1);
      check("stream_last", int'(bus.m_last_o), int'(i == 3 || i == 7));
      step(1);
    end
    check("stream_beats", int'(bus.beat_cnt_o), 8);
    drain(50);
    // Backpressure table: reads stop once the buffer plus inflight word is full
    foreach (vecs[k]) begin
      bus.m_ready_i = 1'b0;
      n0 = n_pop;
      for (int i = 0; i < vecs[k].nwords; i++) push(8'(vecs[k].base + 8'(i)));
      step(8);
      check("bp_reads", n_pop - n0, vecs[k].exp_reads);
      check("bp_valid", int'(bus.m_valid_o), int'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) check("bp_data", int'(bus.m_data_o), int'(vecs[k].exp_data));
      bus.m_ready_i = 1'b1;
      drain(100);
    end
    // en_i drop right after a read: the inflight word still arrives, nothing more is read
    n0 = n_pop;
    d0 = exp_idx;
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    step(1);
    bus.en_i = 1'b0;
    step(6);
    check("endrop_reads", n_pop - n0, 1);
    check("endrop_delivered", exp_idx - d0, 1);
    bus.en_i = 1'b1;
    drain(50);
    // Reset with two words buffered and one inflight
    bus.m_ready_i = 1'b0;
    n0 = n_pop;
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    step(3);
    check("midrst_reads", n_pop - n0, 3);
    rst_i = 1'b0;
    #1;
    check("midrst_valid", int'(bus.m_valid_o), 0);
    check("midrst_beats", int'(bus.beat_cnt_o), 0);
    check("midrst_rd_en", int'(bus.fifo_rd_en_o), 0);
    check("midrst_data", int'(bus.m_data_o), 0);
    step(2);
    rst_i = 1'b1;
    bus.m_ready_i = 1'b1;
    drain(50);
    check("midrst_total_reads", n_pop - n0, 5);
    // Randomized traffic against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) push(8'($urandom));
      bus.m_ready_i = ($urandom_range(0, 3) != 0);
      bus.en_i = ($urandom_range(0, 7) != 0);
      step(1);
    end
    bus.en_i = 1'b1;
    bus.m_ready_i = 1'b1;
    drain(500);
    // Beat counter wrap
    do_reset();
    for (int i = 0; i < 65537; i++) push(8'($urandom));
    drain(70000);
    check("wrap_beats", int'(bus.beat_cnt_o), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_rd_streamer.md
FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 4, meaning beats per packet (legal range 1..255).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en_i, input, 1 bit: when high, the block may issue FIFO reads.
REQ-006 SHALL have port fifo_empty_i, input, 1 bit: empty flag from the upstream synchronous FIFO.
REQ-007 SHALL have port fifo_rdata_i, input, WIDTH bits: upstream FIFO read data, updated on the edge that samples a successful read.
REQ-008 SHALL have port fifo_rd_en_o, output, 1 bit: read request to the upstream FIFO.
REQ-009 SHALL have port m_valid_o, output, 1 bit: output stream word valid.
REQ-010 SHALL have port m_ready_i, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have port m_data_o, output, WIDTH bits: output stream data.
REQ-012 SHALL have port m_last_o, output, 1 bit: marks the final beat of each PKT_LEN-beat packet.
REQ-013 SHALL have port beat_cnt_o, output, 16 bits: total beats transferred since reset, wrapping modulo 2^16.

Function
REQ-014 SHALL contain a 3-entry output buffer (circular, 2-bit read/write pointers, 2-bit occupancy count).
REQ-015 SHALL keep a 1-bit inflight flag: high in the cycle after fifo_rd_en_o was high.
REQ-016 SHALL drive fifo_rd_en_o = en_i AND NOT fifo_empty_i AND (count + inflight < 3), with no combinational path from m_ready_i.
REQ-017 SHALL capture fifo_rdata_i into the buffer at the write pointer on each rising edge where inflight is high, and only then.
REQ-018 SHALL have a read latency of 2 cycles: a word read in cycle N appears on m_data_o with m_valid_o high in cycle N+2 when the buffer was empty.
REQ-019 SHALL drive m_valid_o = (count != 0) and m_data_o = buffer entry at the read pointer.
REQ-020 SHALL treat a transfer as m_valid_o AND m_ready_i; each transfer advances the read pointer.
REQ-021 SHALL hold m_data_o and m_last_o stable while m_valid_o is high and m_ready_i is low.
REQ-022 SHALL, on simultaneous capture and transfer, leave count unchanged and advance both pointers.
REQ-023 SHALL wrap both pointers from 2 to 0.
REQ-024 SHALL sustain one transfer per cycle when the FIFO is non-empty, en_i is high and m_ready_i is held high.
REQ-025 SHALL keep an 8-bit beat index, incremented per transfer and cleared to 0 on the transfer where the index equals PKT_LEN-1.
REQ-026 SHALL assert m_last_o when m_valid_o is high and the beat index equals PKT_LEN-1.
REQ-027 SHALL increment beat_cnt_o by 1 per transfer, wrapping 0xFFFF to 0x0000.
REQ-028 SHALL still capture a word that is inflight when en_i falls; en_i low only blocks new reads.
REQ-029 SHALL never overflow the buffer; count SHALL never exceed 3.

Reset
REQ-030 SHALL, while rst_i is low, asynchronously force count, pointers, inflight, beat index and beat_cnt_o to 0, buffer entries to 0, and m_valid_o, m_last_o and fifo_rd_en_o low.
REQ-031 SHALL discard any inflight word when reset is asserted mid-operation, with no capture on the first edge after release.
REQ-032 SHALL hold m_data_o at 0 after reset until the first capture.

Verification
REQ-033 Single word: FIFO holds 0xA5, en_i=1, m_ready_i=1 -> fifo_rd_en_o high for 1 cycle; m_valid_o high 2 cycles later with m_data_o=0xA5; beat_cnt_o=1.
REQ-034 Streaming: FIFO holds 0x01..0x08, m_ready_i=1 -> 8 consecutive transfers in order; m_last_o on 0x04 and 0x08.
REQ-035 Backpressure: m_ready_i=0 with FIFO holding 5 words -> exactly 3 reads issued, m_data_o stable at first word; m_ready_i=1 -> remaining words follow in order, none lost or duplicated.
REQ-036 en_i drop: en_i falls in the cycle after a read -> the inflight word is still delivered and no further reads occur.
REQ-037 Reset mid-stream: rst_i low with 2 words buffered and 1 inflight -> m_valid_o=0, beat_cnt_o=0 immediately; after release, no spurious output word.
REQ-038 Counter wrap: 65537 transfers -> beat_cnt_o=0x0001.
